// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared definitions for the parallel ADC capture front end.
//   cap_state_e  - capture FSM state encoding
//   MODE_*       - acquisition mode select values for mode_i
//   MIN_PERIOD   - smallest sample-clock period the divider will run at
package adc_cap_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_DONE} cap_state_e;

    localparam logic        MODE_CONT  = 1'b0;
    localparam logic        MODE_BURST = 1'b1;
    localparam int unsigned MIN_PERIOD = 2;
endpackage

// File: rtl/adc_par_capture_if.sv
// adc_par_capture_if: valid/ready sample stream toward the processing chain.
//   m_data_o  - head sample, all channels (channel 0 in the LSBs)
//   m_valid_o - a sample is available
//   m_ready_i - consumer accepts the head sample this cycle
// master = capture block, slave = downstream consumer.
interface adc_par_capture_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 13
) ();
    logic [NUM_CH-1:0][DATA_W-1:0] m_data_o;
    logic                          m_valid_o;
    logic                          m_ready_i;

    modport master (output m_data_o, output m_valid_o, input m_ready_i);
    modport slave  (input m_data_o, input m_valid_o, output m_ready_i);
endinterface

// File: rtl/adc_cap_fifo.sv
// adc_cap_fifo: show-ahead synchronous FIFO.
//   clk, rst  - clock, asynchronous active-high reset
//   push      - write request; accepted when not full or when popping too
//   pop       - read request; ignored when empty
//   wdata     - write data
//   rdata     - head entry, valid whenever count != 0
//   full      - count == DEPTH
//   count     - number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module adc_cap_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          empty, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/adc_par_capture.sv
// adc_par_capture: multi-channel parallel ADC capture front end.
//   clk, rst           - system clock, asynchronous active-high reset
//   en                 - block enable; low forces IDLE and holds the divider
//   mode_i, start_i    - continuous / burst select, burst start pulse
//   burst_len_i        - samples per burst (0 acts as 1)
//   clk_psc_period_i   - sample-clock period P in clk cycles (<2 acts as 2)
//   sample_phase_i     - divider count at which data is latched (>=P acts as P-1)
//   ad_data_i          - ADC buses, channel 0 in the LSBs
//   ad_clk_o           - generated ADC sample clock (registered)
//   m                  - sample stream out of the show-ahead FIFO
//   busy_o, done_o     - ARM/RUN indicator, one-cycle burst completion pulse
//   overflow_o         - sticky dropped-sample flag, cleared by ovf_clr_i
module adc_par_capture import adc_cap_pkg::*; #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 13,
    parameter int PSC_W      = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          mode_i,
    input  logic                          start_i,
    input  logic [LEN_W-1:0]              burst_len_i,
    input  logic [PSC_W-1:0]              clk_psc_period_i,
    input  logic [PSC_W-1:0]              sample_phase_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0] ad_data_i,
    output logic                          ad_clk_o,
    adc_par_capture_if.master             m,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o,
    input  logic                          ovf_clr_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    cap_state_e                 state, state_nxt;
    logic [PSC_W-1:0]           cnt, p_sh, ph_sh, p_clamp, ph_clamp;
    logic [LEN_W-1:0]           scnt, len_eff;
    logic                       burst, wrap, cap, pop, fifo_full;
    logic [CW-1:0]              fifo_count;
    logic [NUM_CH*DATA_W-1:0]   fifo_rdata;

    assign p_clamp  = (clk_psc_period_i < PSC_W'(MIN_PERIOD)) ? PSC_W'(MIN_PERIOD)
                                                              : clk_psc_period_i;
    assign ph_clamp = (sample_phase_i >= p_clamp) ? p_clamp - 1'b1 : sample_phase_i;
    assign len_eff  = (burst_len_i == '0) ? LEN_W'(1) : burst_len_i;

    assign wrap = (cnt == p_sh - 1'b1);
    assign cap  = en && (state == ST_RUN) && (cnt == ph_sh);
    assign pop  = m.m_valid_o & m.m_ready_i;

    // FSM next state and status outputs
    always_comb begin
        state_nxt = state;
        busy_o    = (state == ST_ARM) || (state == ST_RUN);
        done_o    = (state == ST_DONE);
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mode_i == MODE_CONT) state_nxt = ST_RUN;
                    else if (start_i)        state_nxt = ST_ARM;
                end
                // One full warm-up period so the ADC pipeline fills first.
                ST_ARM:  if (wrap) state_nxt = ST_RUN;
                ST_RUN:  if (burst && (scnt == len_eff)) state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Divider, shadow config and ADC clock. Entering IDLE parks cnt/ad_clk at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            p_sh     <= PSC_W'(MIN_PERIOD);
            ph_sh    <= '0;
            ad_clk_o <= 1'b0;
            burst    <= 1'b0;
        end else if (state_nxt == ST_IDLE) begin
            cnt      <= '0;
            ad_clk_o <= 1'b0;
        end else if (state == ST_IDLE) begin
            cnt      <= '0;
            ad_clk_o <= 1'b0;
            p_sh     <= p_clamp;
            ph_sh    <= ph_clamp;
            burst    <= (mode_i == MODE_BURST);
        end else begin
            if (wrap) begin
                cnt   <= '0;
                p_sh  <= p_clamp;
                ph_sh <= ph_clamp;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // P>=2 keeps the set point strictly before the clear point.
            if (cnt == (p_sh >> 1) - 1'b1) ad_clk_o <= 1'b1;
            else if (wrap)                 ad_clk_o <= 1'b0;
        end
    end

    // Burst sample counter counts capture events, dropped ones included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   scnt <= '0;
        else if (state != ST_RUN)  scnt <= '0;
        else if (cap && burst)     scnt <= scnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           overflow_o <= 1'b0;
        else if (cap && fifo_full && !pop) overflow_o <= 1'b1;
        else if (ovf_clr_i)                overflow_o <= 1'b0;
    end

    adc_cap_fifo #(.W(NUM_CH*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap),
        .pop   (pop),
        .wdata (ad_data_i),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign m.m_data_o  = fifo_rdata;
    assign m.m_valid_o = (fifo_count != '0);
endmodule

// File: tb/tb_adc_par_capture.sv
// tb_adc_par_capture: directed self-checking bench for adc_par_capture.
// ADC data ramps with the cycle index (ch0 = cycle, ch1 = cycle+100), so every
// captured word identifies the clk cycle in which it was latched.
module tb_adc_par_capture;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 13;

    logic clk = 1'b0;
    logic rst, en, mode, start, ovf_clr;
    logic [15:0] blen;
    logic [31:0] per, ph;
    logic [NUM_CH-1:0][DATA_W-1:0] ad_data;
    logic ad_clk, busy, done, ovf;
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    adc_par_capture_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    adc_par_capture #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode_i(mode), .start_i(start),
        .burst_len_i(blen), .clk_psc_period_i(per), .sample_phase_i(ph),
        .ad_data_i(ad_data), .ad_clk_o(ad_clk), .m(bus), .busy_o(busy),
        .done_o(done), .overflow_o(ovf), .ovf_clr_i(ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] period;
        logic [31:0] phase;
        int exp_p;
        int exp_high;
        int exp_ph;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance one clk; inputs for the new cycle are applied 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ad_data[0] = DATA_W'(cyc);
        ad_data[1] = DATA_W'(cyc + 100);
    endtask

    task automatic run_burst(input int p, input int len, input int exp_n, input string tag);
        int s, nv, first_v, last_v, last_d, done_t, ndone, busy_pre, busy_at;
        bit warm;
        per = p; ph = 0; blen = 16'(len); mode = 1'b1; en = 1'b1; bus.m_ready_i = 1'b1;
        tick(); tick();
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        nv = 0; first_v = -1; last_v = -1; last_d = -1; done_t = -1; ndone = 0;
        busy_pre = 0; busy_at = 1; warm = 0;
        for (int i = 0; i < (exp_n + 3) * p + 20; i++) begin
            if (bus.m_valid_o) begin
                nv++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                last_d = int'(bus.m_data_o[0]);
            end
            if (ad_clk && first_v < 0) warm = 1;
            if (done) begin
                ndone++;
                if (done_t < 0) begin done_t = cyc; busy_at = busy; end
            end else if (done_t < 0) begin
                busy_pre = busy;
            end
            tick();
        end
        chk({tag, " first_valid_cycle"}, first_v - s, p + 2);
        chk({tag, " warmup_clk"}, warm, 1);
        chk({tag, " sample_count"}, nv, exp_n);
        chk({tag, " last_data"}, last_d, s + p + 1 + (exp_n - 1) * p);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " done_after_last"}, done_t - last_v, 1);
        chk({tag, " busy_at_done"}, busy_at, 0);
        chk({tag, " busy_before_done"}, busy_pre, 1);
    endtask

    initial begin
        int t0, s, r1, r2, hc, v1, v2, c, d1, n, last;
        bit prev;

        vt[0] = '{32'd4, 32'd2,  4, 2, 2};
        vt[1] = '{32'd1, 32'd0,  2, 1, 0};
        vt[2] = '{32'd4, 32'd10, 4, 2, 3};
        vt[3] = '{32'd5, 32'd0,  5, 3, 0};
        vt[4] = '{32'd0, 32'd1,  2, 1, 1};
        vt[5] = '{32'd7, 32'd6,  7, 4, 6};

        rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; ovf_clr = 1'b0;
        blen = '0; per = 32'd4; ph = 32'd2; ad_data = '0; bus.m_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ad_clk", ad_clk, 0);
        chk("reset m_valid", bus.m_valid_o, 0);
        chk("reset m_data", bus.m_data_o, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset overflow", ovf, 0);
        rst = 1'b0;
        tick();

        // Continuous mode: clock shape, capture phase and stream cadence per config.
        for (int k = 0; k < 6; k++) begin
            per = vt[k].period; ph = vt[k].phase; mode = 1'b0; bus.m_ready_i = 1'b1;
            en = 1'b1;
            r1 = -1; r2 = -1; hc = 0; v1 = -1; v2 = -1; c = 0; d1 = 0; prev = 1'b0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (ad_clk && !prev) begin
                    if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
                end
                if (ad_clk && r1 >= 0 && r2 < 0) hc++;
                prev = ad_clk;
                if (bus.m_valid_o) begin
                    if (v1 < 0) begin
                        v1 = cyc; c = int'(bus.m_data_o[0]);
                        d1 = int'(bus.m_data_o[1]) - int'(bus.m_data_o[0]);
                    end else if (v2 < 0 && cyc > v1 + 1) begin
                        v2 = cyc;
                    end
                end
            end
            chk($sformatf("vec%0d clk_period", k), r2 - r1, vt[k].exp_p);
            chk($sformatf("vec%0d clk_high", k), hc, vt[k].exp_high);
            chk($sformatf("vec%0d capture_phase", k),
                (((c - r1 + (vt[k].exp_p >> 1) - vt[k].exp_ph) % vt[k].exp_p) + vt[k].exp_p) % vt[k].exp_p, 0);
            chk($sformatf("vec%0d valid_spacing", k), v2 - v1, vt[k].exp_p);
            chk($sformatf("vec%0d ch1_offset", k), d1, 100);
            en = 1'b0;
            repeat (4) tick();
        end

        // Overflow: P=2, consumer stalled; captures land at t0+1,3,5,7,9,...
        per = 32'd2; ph = 32'd0; mode = 1'b0; bus.m_ready_i = 1'b0;
        en = 1'b1; t0 = cyc;
        while (cyc < t0 + 9) tick();
        chk("ovf before_5th", ovf, 0);
        chk("ovf full_valid", bus.m_valid_o, 1);
        chk("ovf head_data", bus.m_data_o[0], DATA_W'(t0 + 1));
        tick();
        chk("ovf set_on_5th", ovf, 1);
        chk("ovf head_stable", bus.m_data_o[0], DATA_W'(t0 + 1));
        ovf_clr = 1'b1;
        tick();
        chk("ovf cleared", ovf, 0);
        tick();
        chk("ovf set_wins_over_clr", ovf, 1);
        ovf_clr = 1'b0; en = 1'b0;

        // Full FIFO with a pop on the capture cycle: no drop.
        bus.m_ready_i = 1'b1; ovf_clr = 1'b1;
        repeat (8) tick();
        ovf_clr = 1'b0; bus.m_ready_i = 1'b0;
        en = 1'b1; t0 = cyc;
        while (cyc < t0 + 9) tick();
        bus.m_ready_i = 1'b1;
        tick();
        bus.m_ready_i = 1'b0; en = 1'b0;
        chk("fullpop no_overflow", ovf, 0);
        chk("fullpop head_advanced", bus.m_data_o[0], DATA_W'(t0 + 3));
        bus.m_ready_i = 1'b1;
        n = 0; last = -1;
        for (int i = 0; i < 8; i++) begin
            if (bus.m_valid_o) begin n++; last = int'(bus.m_data_o[0]); end
            tick();
        end
        chk("fullpop count_kept", n, 4);
        chk("fullpop newest_sample", last, t0 + 9);

        // Bursts, including a repeat and the zero-length clamp.
        run_burst(6, 5, 5, "burst_a");
        run_burst(6, 5, 5, "burst_b");
        run_burst(2, 0, 1, "burst_len0");

        // Abort: en dropped after two captures (at s+5, s+9) while ad_clk is high.
        per = 32'd4; ph = 32'd0; blen = 16'd8; mode = 1'b1; en = 1'b1; bus.m_ready_i = 1'b0;
        tick();
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        while (cyc < s + 11) tick();
        chk("abort clk_high_before", ad_clk, 1);
        chk("abort busy_before", busy, 1);
        en = 1'b0;
        tick();
        chk("abort clk_low", ad_clk, 0);
        chk("abort busy_low", busy, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) n++;
            tick();
        end
        chk("abort no_done", n, 0);
        bus.m_ready_i = 1'b1;
        n = 0; last = -1; c = -1;
        for (int i = 0; i < 6; i++) begin
            if (bus.m_valid_o) begin
                n++; last = int'(bus.m_data_o[0]);
                if (c < 0) c = last;
            end
            tick();
        end
        chk("abort drained_count", n, 2);
        chk("abort first_sample", c, s + 5);
        chk("abort second_sample", last, s + 9);

        // Asynchronous reset mid-burst, between clock edges.
        en = 1'b1; bus.m_ready_i = 1'b0;
        tick();
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        while (cyc < s + 12) tick();
        chk("rstmid pre_valid", bus.m_valid_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid ad_clk", ad_clk, 0);
        chk("rstmid m_valid", bus.m_valid_o, 0);
        chk("rstmid m_data", bus.m_data_o, 0);
        chk("rstmid busy", busy, 0);
        chk("rstmid done", done, 0);
        chk("rstmid overflow", ovf, 0);
        tick();
        rst = 1'b0; en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/adc_par_capture.md
Name: adc_par_capture

Overview:
Parametrised multi-channel capture front end for parallel-output pipelined ADCs such as the AD9226 family.
- Generates a programmable-ratio ADC sample clock.
- Latches all channels' parallel data at a programmable phase of each clock period.
- Supports continuous or counted-burst acquisition.
- Buffers samples in a small show-ahead FIFO with a valid/ready stream output to the downstream range/Doppler processing chain.

Parameters:
NUM_CH, 2, number of ADC channels sharing one sample clock
DATA_W, 13, bits per channel sample (12 data + OTR)
PSC_W, 32, width of divider period and phase inputs
LEN_W, 16, width of burst length
FIFO_DEPTH, 4, output buffer depth in samples (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  block enable; low = idle, divider held
mode_i  in  1  0 = continuous, 1 = burst
start_i  in  1  burst start pulse (ignored unless mode_i=1 and state IDLE)
burst_len_i  in  LEN_W  samples per burst; 0 treated as 1
clk_psc_period_i  in  PSC_W  sample-clock period P in clk cycles; values <2 treated as 2
sample_phase_i  in  PSC_W  divider count at which data is latched; values >=P treated as P-1
ad_data_i  in  NUM_CH*DATA_W  ADC parallel buses, channel 0 in LSBs
ad_clk_o  out  1  ADC sample clock
m_data_o  out  NUM_CH*DATA_W  FIFO head sample, all channels
m_valid_o  out  1  FIFO not empty
m_ready_i  in  1  downstream accept
busy_o  out  1  state is ARM or RUN
done_o  out  1  one-cycle pulse at burst completion
overflow_o  out  1  sticky: a capture was dropped on full FIFO
ovf_clr_i  in  1  clears overflow_o

Behaviour:
- Reset: all outputs 0; cnt=0; state IDLE; FIFO empty; sample counter 0.
- Config latch: P and phase are clamped, then latched into shadow registers when cnt wraps to 0 and on IDLE->ARM/RUN. Mid-period input changes have no effect until the next wrap.
- Divider: cnt counts 0..P-1 while en=1 and state is not IDLE.
  - ad_clk_o is registered: set at cnt==(P>>1)-1, cleared at cnt==P-1.
  - The high phase therefore spans counts P>>1..P-1 (P=4 gives 2 cycles high, 2 low).
- Capture event: cnt==phase_shadow in state RUN. ad_data_i is latched into the FIFO write port on that cycle.
- Capture latency: m_valid_o rises the next cycle if the FIFO was empty.
- FSM:
  - IDLE: cnt=0, ad_clk_o=0.
    - en & !mode_i -> RUN.
    - en & mode_i & start_i -> ARM.
  - ARM: divider runs from cnt=0 and ad_clk_o toggles. Stays in ARM for exactly one full period, then -> RUN at the wrap, so the first burst sample follows at least one warm-up ADC clock (pipeline fill).
  - RUN (continuous): captures every period until en falls.
  - RUN (burst): the sample counter increments on every capture event, including dropped ones. When counter==max(burst_len,1), next state is DONE.
  - DONE: done_o=1 for one cycle, counter cleared -> IDLE.
- en falling in any state -> IDLE next cycle:
  - cnt=0, ad_clk_o=0, no done_o.
  - FIFO contents and overflow_o are preserved; output draining continues.
- start_i outside IDLE is ignored.
- FIFO:
  - Show-ahead: m_data_o is the head whenever m_valid_o=1.
  - Pop on m_valid_o & m_ready_i.
  - Push when a capture event occurs and (!full or pop in the same cycle). Simultaneous push and pop on full keeps count at DEPTH.
  - Capture while full with no pop: sample dropped, overflow_o <= 1. Set wins over a simultaneous ovf_clr_i.
  - m_data_o holds stable while m_valid_o & !m_ready_i.
- Widths: cnt is PSC_W; comparisons are unsigned; P>>1 is a logical shift.
- Async reset mid-burst returns everything to reset values immediately.

Decomposition:
- Package adc_cap_pkg: FSM state encoding (IDLE, ARM, RUN, DONE), mode constants (MODE_CONT=0, MODE_BURST=1), minimum period constant 2.
- Sub-module adc_cap_fifo: generic show-ahead synchronous FIFO (width, depth parameters; push/pop/full/empty/count).
- Divider, FSM and capture logic live in the top level.

Test Plan:
1. Continuous, P=4, phase=2, ad_data_i ramping +1 per clk, m_ready_i=1 -> ad_clk_o period 4 (high 2 cycles starting at cnt==2); one m_valid_o pulse every 4 cycles carrying the value present at cnt==2.
2. Burst, P=6, burst_len=5, start_i pulse -> one warm-up ad_clk_o period with no valid; exactly 5 samples out; done_o single pulse; busy_o falls with done_o; a second start_i works identically.
3. Overflow: continuous, P=2, m_ready_i=0 -> FIFO fills to 4, overflow_o sets on the 5th capture; m_data_o stays at sample 0; ovf_clr_i clears it, and on a cycle with a simultaneous drop overflow_o stays 1.
4. Clamps: P=1 -> behaves as P=2; sample_phase=10 with P=4 -> capture at cnt==3; burst_len=0 -> exactly 1 sample then done_o.
5. Abort: en dropped mid-burst after 2 of 8 samples -> ad_clk_o low next cycle, no done_o, the 2 buffered samples still drain; rst asserted mid-burst -> all outputs 0 asynchronously.
6. Full with concurrent pop: FIFO full, m_ready_i=1 on the capture cycle -> no drop, overflow_o stays 0, count stays 4.
